// File: rtl/snake_dir_ctrl_if.sv
// Key-press, run-control and heading/tick signals between the
// debounce/game logic (master) and snake_dir_ctrl (slave).
interface snake_dir_ctrl_if;
    logic       leftpress;
    logic       rightpress;
    logic       uppress;
    logic       downpress;
    logic       run;
    logic       restart;
    logic [1:0] dir;
    logic       move_tick;
    logic [2:0] q_count;
    logic       req_drop;

    modport master (
        output leftpress, rightpress, uppress, downpress,
        output run, restart,
        input  dir, move_tick, q_count, req_drop
    );

    modport slave (
        input  leftpress, rightpress, uppress, downpress,
        input  run, restart,
        output dir, move_tick, q_count, req_drop
    );
endinterface

// File: rtl/snake_dir_ctrl.sv
// Snake heading controller: queues up to QDEPTH legal turns, applies one
// per move tick, and generates the periodic move tick.
// Ports: clk, rst (sync, active-low), bus (snake_dir_ctrl_if.slave):
//   presses/run/restart in; dir, move_tick, q_count, req_drop out.
module snake_dir_ctrl #(
    parameter int         QDEPTH   = 2,
    parameter int         TICK_DIV = 25000000,
    parameter logic [1:0] INIT_DIR = 2'd1
) (
    input logic             clk,
    input logic             rst,
    snake_dir_ctrl_if.slave bus
);
    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PLAST = PW'(QDEPTH - 1);
    localparam logic [CW-1:0] CLAST = CW'(TICK_DIV - 1);
    localparam logic [2:0]    QFULL = 3'(QDEPTH);

    logic [1:0]    q [QDEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [2:0]    cnt;
    logic [CW-1:0] ctr;
    logic [1:0]    dir_r;
    logic          tick_r;
    logic          drop_r;

    logic [2:0]    npress;
    logic          one;
    logic [1:0]    rd;
    logic [PW-1:0] tail_prev;
    logic [1:0]    ref_d;
    logic          accept;
    logic          drop;
    logic          wrap;
    logic          pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PLAST) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        npress = 3'(bus.leftpress) + 3'(bus.rightpress)
               + 3'(bus.uppress) + 3'(bus.downpress);
        one = (npress == 3'd1);
        rd  = 2'd0;
        // Decode only when exactly one press is high.
        if (one) begin
            unique case (1'b1)
                bus.uppress:    rd = 2'd0;
                bus.rightpress: rd = 2'd1;
                bus.downpress:  rd = 2'd2;
                bus.leftpress:  rd = 2'd3;
            endcase
        end
        tail_prev = (tail == '0) ? PLAST : tail - PW'(1);
        // Check against the newest pending turn, not the live heading.
        ref_d  = (cnt != 3'd0) ? q[tail_prev] : dir_r;
        // Full means dropped even if a pop happens on the same edge.
        accept = one && bus.run && (rd != ref_d)
              && (rd != (ref_d ^ 2'd2)) && (cnt != QFULL);
        drop   = (one && !accept) || (npress > 3'd1);
        wrap   = bus.run && (ctr == CLAST);
        pop    = wrap && (cnt != 3'd0);
    end

    always_ff @(posedge clk) begin
        if (!rst || bus.restart) begin
            for (int i = 0; i < QDEPTH; i++) q[i] <= 2'd0;
            head   <= '0;
            tail   <= '0;
            cnt    <= 3'd0;
            ctr    <= '0;
            dir_r  <= INIT_DIR;
            tick_r <= 1'b0;
            drop_r <= 1'b0;
        end else begin
            tick_r <= wrap;
            drop_r <= drop;
            if (bus.run) ctr <= wrap ? '0 : ctr + CW'(1);
            if (accept) begin
                q[tail] <= rd;
                tail    <= nxt(tail);
            end
            if (pop) begin
                dir_r <= q[head];
                head  <= nxt(head);
            end
            case ({accept, pop})
                2'b10:   cnt <= cnt + 3'd1;
                2'b01:   cnt <= cnt - 3'd1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign bus.dir       = dir_r;
    assign bus.move_tick = tick_r;
    assign bus.q_count   = cnt;
    assign bus.req_drop  = drop_r;
endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Directed self-checking bench for snake_dir_ctrl
// (QDEPTH=2, TICK_DIV=8, INIT_DIR=1).
module tb_snake_dir_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   miscompares = 0;

    snake_dir_ctrl_if sif ();

    snake_dir_ctrl #(
        .QDEPTH   (2),
        .TICK_DIV (8),
        .INIT_DIR (2'd1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (sif.slave)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        sif.leftpress  = 1'b0;
        sif.rightpress = 1'b0;
        sif.uppress    = 1'b0;
        sif.downpress  = 1'b0;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic expect_st(input string tag, input int d, input int mt,
                             input int qc, input int dr);
        chk({tag, ".dir"}, int'(sif.dir), d);
        chk({tag, ".move_tick"}, int'(sif.move_tick), mt);
        chk({tag, ".q_count"}, int'(sif.q_count), qc);
        chk({tag, ".req_drop"}, int'(sif.req_drop), dr);
    endtask

    initial begin
        // Reset overrides presses and run.
        rst = 1'b0;
        sif.run = 1'b1;
        sif.restart = 1'b0;
        clr();
        sif.leftpress = 1'b1;
        sif.uppress = 1'b1;
        step();
        expect_st("reset", 1, 0, 0, 0);
        clr();
        rst = 1'b1;

        // 1: free-running ticks every 8 cycles, first at edge 8.
        for (int k = 1; k <= 16; k++) begin
            step();
            expect_st("t1", 1, (k % 8 == 0) ? 1 : 0, 0, 0);
        end

        // 2: reversal and duplicate dropped, then up queued.
        sif.leftpress = 1'b1; step(); clr();
        expect_st("t2_rev", 1, 0, 0, 1);
        sif.rightpress = 1'b1; step(); clr();
        expect_st("t2_dup", 1, 0, 0, 1);
        sif.uppress = 1'b1; step(); clr();
        expect_st("t2_up", 1, 0, 1, 0);
        repeat (4) step();
        expect_st("t2_pre", 1, 0, 1, 0);
        step();
        expect_st("t2_tick", 0, 1, 0, 0);

        // Restart back to heading right.
        sif.restart = 1'b1; step(); sif.restart = 1'b0;
        expect_st("t3_rst", 1, 0, 0, 0);

        // 3: up, left accepted; down dropped.
        sif.uppress = 1'b1; step(); clr();
        expect_st("t3_up", 1, 0, 1, 0);
        sif.leftpress = 1'b1; step(); clr();
        expect_st("t3_left", 1, 0, 2, 0);
        sif.downpress = 1'b1; step(); clr();
        expect_st("t3_down", 1, 0, 2, 1);
        repeat (4) step();
        expect_st("t4_pre", 1, 0, 2, 0);

        // 4: press on the tick edge while full is dropped.
        sif.uppress = 1'b1; step(); clr();
        expect_st("t4_tick", 0, 1, 1, 1);
        repeat (7) step();
        expect_st("t3_pre2", 0, 0, 1, 0);
        step();
        expect_st("t3_tick2", 3, 1, 0, 0);

        // Push and pop on the same edge with one entry queued.
        sif.uppress = 1'b1; step(); clr();
        expect_st("pp_push", 3, 0, 1, 0);
        repeat (6) step();
        sif.leftpress = 1'b1; step(); clr();
        expect_st("pp_tick", 0, 1, 1, 0);
        repeat (8) step();
        expect_st("pp_tick2", 3, 1, 0, 0);

        // 5: malformed press, then paused press and frozen counter.
        sif.leftpress = 1'b1;
        sif.uppress = 1'b1;
        step(); clr();
        expect_st("t5_multi", 3, 0, 0, 1);
        sif.run = 1'b0;
        sif.uppress = 1'b1; step(); clr();
        expect_st("t5_pause", 3, 0, 0, 1);
        for (int k = 0; k < 20; k++) begin
            step();
            expect_st("t5_frozen", 3, 0, 0, 0);
        end
        sif.run = 1'b1;
        for (int j = 1; j <= 7; j++) begin
            step();
            expect_st("t5_resume", 3, (j == 7) ? 1 : 0, 0, 0);
        end

        // 6: two queued turns with dir=0, then restart mid-count.
        sif.uppress = 1'b1; step(); clr();
        expect_st("t6_q1", 3, 0, 1, 0);
        sif.rightpress = 1'b1; step(); clr();
        expect_st("t6_q2", 3, 0, 2, 0);
        repeat (5) step();
        step();
        expect_st("t6_tick", 0, 1, 1, 0);
        sif.downpress = 1'b1; step(); clr();
        expect_st("t6_q2b", 0, 0, 2, 0);
        repeat (2) step();
        sif.restart = 1'b1;
        sif.leftpress = 1'b1;
        sif.uppress = 1'b1;
        step(); clr();
        sif.restart = 1'b0;
        expect_st("t6_rst", 1, 0, 0, 0);
        for (int k = 1; k <= 8; k++) begin
            step();
            expect_st("t6_after", 1, (k == 8) ? 1 : 0, 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
